// File: rtl/bus_select_arbiter.sv
// bus_select_arbiter: round-robin owner selection for a shared 4-source tri-state bus,
// with a bounded tenure per owner and one dead turnaround cycle between owners.
module bus_select_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       oe,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // Returns {valid, index}; scanning from the far end lets the nearest candidate after prev win.
  function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] prev);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = prev + 2'(k);
      if (r[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       owner_r, owner_s;
  logic [1:0]       last_r, last_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [3:0]       gnt_s;
  logic [1:0]       sel_s;
  logic             oe_s;
  logic             busy_s;
  logic [2:0]       win_s;
  logic             release_s;

  assign win_s     = pick_winner(req, last_r);
  assign release_s = done | ~req[owner_r] | (hold_cnt_r == HOLD_LAST);

  // Next-state and next-output logic; outputs only change at GRANT entry or release.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    last_s     = last_r;
    hold_cnt_s = hold_cnt_r;
    gnt_s      = gnt;
    sel_s      = {s1, s0};
    oe_s       = oe;
    busy_s     = busy;
    case (state_r)
      ST_IDLE, ST_TURN: begin
        if (win_s[2]) begin
          state_s    = ST_GRANT;
          owner_s    = win_s[1:0];
          gnt_s      = 4'b0001 << win_s[1:0];
          sel_s      = win_s[1:0];
          oe_s       = 1'b1;
          busy_s     = 1'b1;
          hold_cnt_s = '0;
        end else begin
          state_s = ST_IDLE;
          gnt_s   = 4'b0000;
          oe_s    = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_s    = ST_TURN;
          last_s     = owner_r;
          gnt_s      = 4'b0000;
          oe_s       = 1'b0;
          busy_s     = 1'b1;
          hold_cnt_s = '0;
        end else begin
          hold_cnt_s = hold_cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = 4'b0000;
        oe_s    = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      owner_r    <= 2'd0;
      last_r     <= 2'd3;
      hold_cnt_r <= '0;
      gnt        <= 4'b0000;
      s0         <= 1'b0;
      s1         <= 1'b0;
      oe         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      last_r     <= last_s;
      hold_cnt_r <= hold_cnt_s;
      gnt        <= gnt_s;
      s0         <= sel_s[0];
      s1         <= sel_s[1];
      oe         <= oe_s;
      busy       <= busy_s;
    end
  end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Bench for bus_select_arbiter: directed scenarios plus randomized traffic against a
// tenure-level reference model, on three instances (HOLD_MAX = 8, 4, 1).
module tb_bus_select_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  logic [3:0] gnt_a  [3];
  logic       s0_a   [3];
  logic       s1_a   [3];
  logic       oe_a   [3];
  logic       busy_a [3];

  int checks;
  int errors;

  // Reference model: phase 0 = no owner, 1 = owned, 2 = gap cycle
  int hold_max [3] = '{8, 4, 1};
  int m_phase  [3];
  int m_owner  [3];
  int m_last   [3];
  int m_held   [3];
  int m_sel    [3];

  bus_select_arbiter #(.HOLD_MAX(8)) u_h8 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_a[0]), .s0(s0_a[0]), .s1(s1_a[0]), .oe(oe_a[0]), .busy(busy_a[0])
  );
  bus_select_arbiter #(.HOLD_MAX(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_a[1]), .s0(s0_a[1]), .s1(s1_a[1]), .oe(oe_a[1]), .busy(busy_a[1])
  );
  bus_select_arbiter #(.HOLD_MAX(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_a[2]), .s0(s0_a[2]), .s1(s1_a[2]), .oe(oe_a[2]), .busy(busy_a[2])
  );

  always #5 clk = ~clk;

  function automatic int rr_winner(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++) begin
      if (r[(last + off) % 4]) return (last + off) % 4;
    end
    return 0;
  endfunction

  task automatic model_edge(input int d);
    if (rst) begin
      m_phase[d] = 0; m_owner[d] = 0; m_last[d] = 3; m_held[d] = 0; m_sel[d] = 0;
    end else if (m_phase[d] == 1) begin
      if (done || !req[m_owner[d]] || m_held[d] == hold_max[d]) begin
        m_phase[d] = 2;
        m_last[d]  = m_owner[d];
      end else begin
        m_held[d]++;
      end
    end else if (req != 4'b0000) begin
      m_owner[d] = rr_winner(req, m_last[d]);
      m_sel[d]   = m_owner[d];
      m_held[d]  = 1;
      m_phase[d] = 1;
    end else begin
      m_phase[d] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    step(); step();
    checks++;
    if (gnt_a[0] !== 4'b0000 || oe_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got gnt=%b oe=%b busy=%b want 0000 0 0", gnt_a[0], oe_a[0], busy_a[0]);
    end
    checks++;
    if ({s1_a[0], s0_a[0]} !== 2'b00) begin
      errors++;
      $display("FAIL reset_sel got %b want 00", {s1_a[0], s0_a[0]});
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt_a[0] !== 4'b0001 || oe_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got gnt=%b oe=%b want 0001 1", gnt_a[0], oe_a[0]);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (gnt_a[0] !== 4'b0100 || {s1_a[0], s0_a[0]} !== 2'b10 || oe_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got gnt=%b sel=%b oe=%b want 0100 10 1",
               gnt_a[0], {s1_a[0], s0_a[0]}, oe_a[0]);
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (oe_a[0] !== 1'b1) break;
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL single_tenure got %0d cycles want 8", n);
    end
    checks++;
    if (oe_a[0] !== 1'b0 || gnt_a[0] !== 4'b0000 || {s1_a[0], s0_a[0]} !== 2'b10) begin
      errors++;
      $display("FAIL single_turn got oe=%b gnt=%b sel=%b want 0 0000 10",
               oe_a[0], gnt_a[0], {s1_a[0], s0_a[0]});
    end
    step();
    checks++;
    if (gnt_a[0] !== 4'b0100 || oe_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_regrant got gnt=%b oe=%b want 0100 1", gnt_a[0], oe_a[0]);
    end
  endtask

  task automatic test_rotation();
    int n;
    logic [3:0] want;
    do_reset();
    req = 4'b1111;
    step();
    for (int t = 0; t < 5; t++) begin
      want = 4'b0001 << (t % 4);
      checks++;
      if (gnt_a[1] !== want || {s1_a[1], s0_a[1]} !== 2'(t % 4)) begin
        errors++;
        $display("FAIL rotation_owner t=%0d got gnt=%b sel=%b want %b", t, gnt_a[1],
                 {s1_a[1], s0_a[1]}, want);
      end
      n = 1;
      for (int i = 0; i < 10; i++) begin
        step();
        checks++;
        if ($countones(gnt_a[1]) > 1) begin
          errors++;
          $display("FAIL rotation_onehot got gnt=%b want at most one bit", gnt_a[1]);
        end
        if (oe_a[1] !== 1'b1) break;
        n++;
      end
      checks++;
      if (n != 4) begin
        errors++;
        $display("FAIL rotation_tenure t=%0d got %0d cycles want 4", t, n);
      end
      step();
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b1010;
    step();
    checks++;
    if (gnt_a[0] !== 4'b0010) begin
      errors++;
      $display("FAIL early_first got gnt=%b want 0010", gnt_a[0]);
    end
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (oe_a[0] !== 1'b0 || gnt_a[0] !== 4'b0000 || busy_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL early_turn got oe=%b gnt=%b busy=%b want 0 0000 1", oe_a[0], gnt_a[0], busy_a[0]);
    end
    step();
    checks++;
    if (gnt_a[0] !== 4'b1000 || {s1_a[0], s0_a[0]} !== 2'b11 || oe_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL early_next got gnt=%b sel=%b oe=%b want 1000 11 1",
               gnt_a[0], {s1_a[0], s0_a[0]}, oe_a[0]);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b0100;
    step(); step();
    req = 4'b0000;
    step();
    checks++;
    if (oe_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL drop_turn got oe=%b busy=%b want 0 1", oe_a[0], busy_a[0]);
    end
    step();
    checks++;
    if (busy_a[0] !== 1'b0 || gnt_a[0] !== 4'b0000 || {s1_a[0], s0_a[0]} !== 2'b10) begin
      errors++;
      $display("FAIL drop_idle got busy=%b gnt=%b sel=%b want 0 0000 10",
               busy_a[0], gnt_a[0], {s1_a[0], s0_a[0]});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    step();
    checks++;
    if (gnt_a[0] !== 4'b1000 || {s1_a[0], s0_a[0]} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_grant got gnt=%b sel=%b want 1000 11", gnt_a[0], {s1_a[0], s0_a[0]});
    end
    rst = 1'b1;
    step();
    checks++;
    if (oe_a[0] !== 1'b0 || gnt_a[0] !== 4'b0000 || {s1_a[0], s0_a[0]} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_clear got oe=%b gnt=%b sel=%b want 0 0000 00",
               oe_a[0], gnt_a[0], {s1_a[0], s0_a[0]});
    end
    rst = 1'b0;
    req = 4'b1001;
    step();
    checks++;
    if (gnt_a[0] !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_restart got gnt=%b want 0001", gnt_a[0]);
    end
  endtask

  task automatic test_hold_one();
    do_reset();
    req = 4'b0010;
    step();
    checks++;
    if (gnt_a[2] !== 4'b0010 || oe_a[2] !== 1'b1) begin
      errors++;
      $display("FAIL hold1_grant got gnt=%b oe=%b want 0010 1", gnt_a[2], oe_a[2]);
    end
    step();
    checks++;
    if (oe_a[2] !== 1'b0 || gnt_a[2] !== 4'b0000) begin
      errors++;
      $display("FAIL hold1_turn got oe=%b gnt=%b want 0 0000", oe_a[2], gnt_a[2]);
    end
    step();
    checks++;
    if (gnt_a[2] !== 4'b0010 || oe_a[2] !== 1'b1) begin
      errors++;
      $display("FAIL hold1_regrant got gnt=%b oe=%b want 0010 1", gnt_a[2], oe_a[2]);
    end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      step();
      for (int d = 0; d < 3; d++) begin
        eg = (m_phase[d] == 1) ? (4'b0001 << m_owner[d]) : 4'b0000;
        checks++;
        if (gnt_a[d] !== eg || oe_a[d] !== (m_phase[d] == 1) || busy_a[d] !== (m_phase[d] != 0)
            || {s1_a[d], s0_a[d]} !== 2'(m_sel[d])) begin
          errors++;
          $display("FAIL random d=%0d cyc=%0d got gnt=%b oe=%b busy=%b sel=%b want %b %0d %0d %0d",
                   d, cyc, gnt_a[d], oe_a[d], busy_a[d], {s1_a[d], s0_a[d]}, eg,
                   (m_phase[d] == 1), (m_phase[d] != 0), m_sel[d]);
        end
      end
    end
    rst = 1'b0; done = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req = 4'b0000; done = 1'b0;
    checks = 0; errors = 0;
    for (int d = 0; d < 3; d++) begin
      m_phase[d] = 0; m_owner[d] = 0; m_last[d] = 3; m_held[d] = 0; m_sel[d] = 0;
    end
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_req_drop();
    test_reset_mid();
    test_hold_one();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
